// File: rtl/stream_serializer_pkg.sv
// stream_serializer_pkg: shared word-count type, count clamping helper and ratio limit
package stream_serializer_pkg;
  localparam int RATIO_MIN = 2;
  // Wide enough for any practical ratio; callers resize to their own CW.
  typedef logic [7:0] wcount_t;
  // Effective narrow-word count of a wide beat: full unless a final beat names a legal count.
  function automatic wcount_t clamp_words(input logic last, input wcount_t words, input int ratio);
    return (!last || words == '0 || int'(words) > ratio) ? wcount_t'(ratio) : words;
  endfunction
endpackage

// File: rtl/stream_serializer.sv
// stream_serializer: unpacks one RATIO*DATA_WIDTH beat into up to RATIO narrow beats, LSB word first
module stream_serializer
  import stream_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO = 4,
  parameter int CW = $clog2(RATIO + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [RATIO*DATA_WIDTH-1:0] s_data,
  input  logic [CW-1:0]               s_words,
  input  logic                        s_last,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_last,
  output logic                        m_valid,
  input  logic                        m_ready
);
  if (RATIO < RATIO_MIN) begin : g_bad_ratio
    $error("stream_serializer: RATIO must be at least 2");
  end
  typedef enum logic {IDLE, SEND} state_t;
  state_t                      state_q, state_d;
  logic [CW-1:0]               idx_q, idx_d, n_q, n_d;
  logic                        last_q, last_d;
  logic [RATIO*DATA_WIDTH-1:0] data_q, data_d;
  logic                        last_word, in_xfer, out_xfer;
  assign last_word = idx_q == n_q - CW'(1);
  assign m_valid   = state_q == SEND;
  assign m_data    = data_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign m_last    = m_valid && last_q && last_word;
  assign out_xfer  = m_valid && m_ready;
  // A new beat is taken while idle or in the same cycle the final word of the held beat leaves.
  assign s_ready   = !rst && (state_q == IDLE || (out_xfer && last_word));
  assign in_xfer   = s_valid && s_ready;
  // Holding register and word index: reload on input accept, otherwise step through words.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    last_d  = last_q;
    data_d  = data_q;
    if (in_xfer) begin
      state_d = SEND;
      idx_d   = '0;
      n_d     = CW'(clamp_words(s_last, wcount_t'(s_words), RATIO));
      last_d  = s_last;
      data_d  = s_data;
    end else if (out_xfer) begin
      state_d = last_word ? IDLE : SEND;
      idx_d   = last_word ? idx_q : idx_q + CW'(1);
    end
  end
  // State register; reset discards any partially sent beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_stream_serializer.sv
// tb_stream_serializer: scoreboard-driven directed and random checks of the wide-to-narrow serializer
module tb_stream_serializer;
  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] s_data = '0;
  logic [2:0]  s_words = '0;
  logic        s_last = 0;
  logic        s_valid = 0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int out_cnt = 0;
  int oc[$];
  logic [8:0] sb[$];
  logic rnd = 0;
  logic prev_stall = 0;
  logic [8:0] prev_w = '0;

  stream_serializer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_words(s_words), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rnd) #1 m_ready = 1'($urandom_range(0, 1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: stall stability and in-order comparison against the scoreboard.
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("hold_valid", {31'd0, m_valid}, 1);
      chk("hold_word", {23'd0, m_last, m_data}, {23'd0, prev_w});
    end
    if (m_valid && m_ready) begin
      if (sb.size() == 0) chk("unexpected_word", sb.size(), 1);
      else chk("word", {23'd0, m_last, m_data}, {23'd0, sb.pop_front()});
      out_cnt++;
      oc.push_back(cyc);
    end
    prev_stall = m_valid && !m_ready;
    prev_w = {m_last, m_data};
  end

  task automatic send(input logic [31:0] d, input logic [2:0] w, input logic l,
                      output logic acc_v, output logic [8:0] acc_w);
    int n;
    int b;
    s_data = d; s_words = w; s_last = l; s_valid = 1;
    b = 0;
    @(negedge clk);
    while (!s_ready && b < 200) begin @(negedge clk); b++; end
    acc_v = m_valid;
    acc_w = {m_last, m_data};
    if (!s_ready) chk("accept_timeout", {31'd0, s_ready}, 1);
    else begin
      n = (!l || w == 0 || w > 4) ? 4 : int'(w);
      for (int k = 0; k < n; k++) sb.push_back({l && k == n - 1, d[k*8 +: 8]});
    end
    @(posedge clk); #1;
    s_valid = 0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((sb.size() != 0 || m_valid) && b < 400) begin @(posedge clk); b++; end
    #1;
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    logic av;
    logic [8:0] aw;
    int base;
    int b;
    int nb;
    #2;
    chk("rst_valid", {31'd0, m_valid}, 0);
    chk("rst_last", {31'd0, m_last}, 0);
    chk("rst_data", {24'd0, m_data}, 0);
    chk("rst_sready", {31'd0, s_ready}, 0);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("sready_after_rst", {31'd0, s_ready}, 1);
    @(posedge clk); #1;
    // single full beat
    base = out_cnt;
    send(32'h44332211, 3'd4, 1'b1, av, aw);
    chk("latency_valid", {31'd0, m_valid}, 1);
    chk("first_word", {24'd0, m_data}, 32'h11);
    drain();
    chk("full_count", out_cnt - base, 4);
    // back-to-back beats, no bubbles
    base = out_cnt;
    send(32'h04030201, 3'd0, 1'b0, av, aw);
    send(32'h08070605, 3'd0, 1'b0, av, aw);
    chk("b2b_accept_on_w4", {23'd0, av, aw}, {23'd0, 1'b1, 1'b0, 8'h04});
    send(32'h0C0B0A09, 3'd4, 1'b1, av, aw);
    chk("b2b_accept_on_w8", {23'd0, av, aw}, {23'd0, 1'b1, 1'b0, 8'h08});
    drain();
    chk("b2b_count", out_cnt - base, 12);
    chk("b2b_no_bubble", oc[oc.size()-1] - oc[oc.size()-12], 11);
    // partial final beat, next beat taken alongside its last word
    base = out_cnt;
    send(32'hAABBCCDD, 3'd2, 1'b1, av, aw);
    send(32'h14131211, 3'd4, 1'b1, av, aw);
    chk("partial_overlap", {23'd0, av, aw}, {23'd0, 1'b1, 1'b1, 8'hCC});
    drain();
    chk("partial_count", out_cnt - base, 6);
    // edge word counts
    base = out_cnt; send(32'h24232221, 3'd0, 1'b1, av, aw); drain();
    chk("words0_count", out_cnt - base, 4);
    base = out_cnt; send(32'h34333231, 3'd7, 1'b1, av, aw); drain();
    chk("words7_count", out_cnt - base, 4);
    base = out_cnt; send(32'h44434241, 3'd1, 1'b1, av, aw); drain();
    chk("words1_count", out_cnt - base, 1);
    base = out_cnt; send(32'h54535251, 3'd3, 1'b0, av, aw);
    send(32'h64636261, 3'd3, 1'b1, av, aw); drain();
    chk("nonlast_count", out_cnt - base, 7);
    // reset in the middle of a beat
    base = out_cnt;
    send(32'hDDCCBBAA, 3'd4, 1'b1, av, aw);
    b = 0;
    while (out_cnt < base + 2 && b < 50) begin @(posedge clk); b++; end
    #1 rst = 1;
    #1;
    chk("midrst_valid", {31'd0, m_valid}, 0);
    chk("midrst_sready", {31'd0, s_ready}, 0);
    chk("midrst_sent", out_cnt - base, 2);
    sb.delete();
    @(posedge clk); @(posedge clk); #1 rst = 0;
    base = out_cnt;
    send(32'h0D0C0B0A, 3'd4, 1'b1, av, aw);
    chk("post_rst_first", {23'd0, m_last, m_data}, {23'd0, 1'b0, 8'h0A});
    drain();
    chk("post_rst_count", out_cnt - base, 4);
    // random backpressure over many packets
    base = out_cnt;
    rnd = 1;
    for (int p = 0; p < 1000; p++) begin
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send($urandom, 3'($urandom_range(0, 7)), k == nb - 1, av, aw);
      end
    end
    drain();
    rnd = 0;
    @(posedge clk); #2 m_ready = 1;
    chk("random_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/stream_serializer.md
Name: stream_serializer

Overview:
- Wide-to-narrow stream converter (transmitter side of a stream width-conversion pair). The matching upsizer/deserializer packs narrow beats; this block unpacks them.
- Accepts one RATIO*DATA_WIDTH beat on a slave stream port and emits RATIO (or fewer, on the final beat of a packet) DATA_WIDTH beats on a master stream port.
- Sits between a wide datapath and a narrow link, e.g. ahead of reg_slice on the master side of a stream_if.

Parameters:
- DATA_WIDTH, 32, width of one narrow output word.
- RATIO, 4, narrow words per wide input beat (>=2).
- CW, $clog2(RATIO+1), width of the s_words field (derived; not to be overridden).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- s_data  in  RATIO*DATA_WIDTH  wide input word; word k = s_data[k*DATA_WIDTH +: DATA_WIDTH].
- s_words  in  CW  valid narrow words in this beat when s_last=1 (1..RATIO; 0 or >RATIO treated as RATIO); ignored when s_last=0.
- s_last  in  1  final wide beat of packet.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept input beat.
- m_data  out  DATA_WIDTH  narrow output word.
- m_last  out  1  final narrow word of packet.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts word.

Behaviour:
- Transfer on a port occurs when valid&&ready at the rising clk edge.
- Reset (async assert, sync release): m_valid=0, m_last=0, m_data=0, index=0, state IDLE. s_ready=0 while rst=1, and 1 from the first cycle after release.
- Holding register: captures s_data, an effective count N (RATIO if s_last=0, else clamped s_words), and s_last on input transfer.
- States:
  - IDLE: m_valid=0, s_ready=1. On input transfer, go to SEND with index=0.
  - SEND: m_valid=1, m_data=word[index], m_last = held_last && (index==N-1).
- Transitions in SEND on output transfer:
  - index<N-1: index++.
  - index==N-1 and input transfer in the same cycle: reload the holding register, index=0, stay in SEND (no bubble).
  - index==N-1 and no input transfer: go to IDLE.
- s_ready = IDLE || (m_valid && m_ready && index==N-1). This is a combinational path from m_ready, which is allowed.
- Latency: first narrow word is valid 1 cycle after the wide accept. Sustained throughput is 1 narrow word/cycle with no bubbles between wide beats.
- Word order: LSB word first. m_data, m_last, and m_valid must be stable while m_valid=1 && m_ready=0 (stream protocol).
- N=1 (s_last=1, s_words=1): single output word with m_last=1. s_ready is combinational on its acceptance.
- Words beyond N in the held beat are never emitted.
- s_valid when s_ready=0: no capture, no state change. s_valid may drop without a transfer.
- rst mid-packet: all state is discarded immediately (async). No partial-packet flush.

Decomposition:
- The shared stream package holds:
  - the typedef for the word-count type (logic [CW-1:0]),
  - a function clamp_words(s_last, s_words) returning N,
  - a localparam RATIO_MIN=2 for the elaboration check.
- Elaboration assertion: RATIO>=2.
- Single module. No sub-module is natural. Timing isolation uses an external reg_slice instance, not an internal one.

Test Plan (DATA_WIDTH=8, RATIO=4):
- Single full beat: s_data=0x44332211, s_last=1, s_words=4, m_ready=1 -> m_data 11,22,33,44 on 4 consecutive cycles, starting 1 cycle after accept. m_last only on 44.
- Back-to-back: 3 beats with s_last=0,0,1 and s_valid held high, m_ready=1 -> 12 contiguous output words with no bubble. s_ready pulses on words 4 and 8. m_last only on word 12.
- Partial final beat: s_data=0xAABBCCDD, s_last=1, s_words=2 -> outputs DD then CC (m_last=1 on CC). BB/AA are never emitted. The next beat is accepted in the same cycle as CC.
- Edge counts: s_words=0 and s_words=7 with s_last=1 -> 4 words out. s_words=1 -> one word with m_last=1. s_words=3 with s_last=0 -> 4 words, m_last=0.
- Backpressure: random m_ready (50%) with a random-driver slave agent -> m_data/m_last hold stable while stalled. The checker's predicted narrow stream matches the actual output exactly over 1000 packets.
- Reset mid-packet: assert rst after 2 of 4 words have been output -> m_valid=0 immediately and s_ready=0 during reset. After release, a new beat 0x0D0C0B0A outputs 0A..0D with no leftover words.
